// File: rtl/reverb_delay_line_ctrl_pkg.sv
// Shared types and constants for the reverb delay-line controller.
package reverb_delay_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 11;

  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    OUT,
    CLEAR
  } state_t;

endpackage

// File: rtl/reverb_delay_line_ctrl_if.sv
// Sample stream in/out plus the Avalon-MM master port toward the delay RAM.
interface reverb_delay_line_ctrl_if
  import reverb_delay_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] delay;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    input  in_valid, in_data, delay, mem_readdata,
    output in_ready, out_valid, out_data,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );

  modport slave (
    output in_valid, in_data, delay, mem_readdata,
    input  in_ready, out_valid, out_data,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );

endinterface

// File: rtl/reverb_delay_line_ctrl.sv
// Reverb delay-line controller: circular buffer on a single-port RAM, read old then write new.
// Build option DELAY_CLEAR_EN zeroes the whole buffer after every reset before accepting samples.
//
// state | meaning
// IDLE  | in_ready high, wait for a sample
// RD    | read the sample `delay` entries back
// WR    | write new sample at wr_ptr, capture readdata
// OUT   | one-cycle out_valid strobe
// CLEAR | post-reset zero sweep (DELAY_CLEAR_EN only)
module reverb_delay_line_ctrl
  import reverb_delay_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input logic                      clk,
  input logic                      reset,
  reverb_delay_line_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [DATA_W-1:0] s_reg;
  logic [ADDR_W-1:0] d_reg;

  assign bus.mem_byteenable = BE_ALL;
  assign wr_ptr_next        = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DELAY_CLEAR_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      wr_ptr             <= '0;
      s_reg              <= '0;
      d_reg              <= '0;
      bus.in_ready       <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid      <= 1'b0;
          bus.mem_chipselect <= 1'b0;
          bus.mem_write      <= 1'b0;
          if (bus.in_ready && bus.in_valid) begin
            s_reg              <= bus.in_data;
            d_reg              <= bus.delay;
            // modulo-DEPTH subtraction falls out of the ADDR_W-bit wrap
            bus.mem_address    <= wr_ptr - bus.delay;
            bus.mem_chipselect <= 1'b1;
            bus.in_ready       <= 1'b0;
            state              <= RD;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        RD: begin
          bus.mem_write     <= 1'b1;
          bus.mem_address   <= wr_ptr;
          bus.mem_writedata <= s_reg;
          state             <= WR;
        end
        WR: begin
          // delay 0 reads the slot being overwritten, so forward the sample itself
          bus.out_data       <= (d_reg == '0) ? s_reg : bus.mem_readdata;
          bus.out_valid      <= 1'b1;
          bus.mem_chipselect <= 1'b0;
          bus.mem_write      <= 1'b0;
          wr_ptr             <= wr_ptr_next;
          state              <= OUT;
        end
        OUT: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
`ifdef DELAY_CLEAR_EN
        CLEAR: begin
          bus.mem_chipselect <= 1'b1;
          bus.mem_write      <= 1'b1;
          bus.mem_address    <= wr_ptr;
          bus.mem_writedata  <= '0;
          wr_ptr             <= wr_ptr_next;
          if (wr_ptr == LAST_ADDR) begin
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
`endif
        default: begin
          bus.in_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_delay_line_ctrl.sv
// Self-checking bench for reverb_delay_line_ctrl with a behavioural 2048x16 RAM and a buffer model.
module tb_reverb_delay_line_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  reverb_delay_line_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reverb_delay_line_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // single-port RAM, registered read
  logic [DW-1:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      else               bus.mem_readdata     <= ram[bus.mem_address];
    end
  end

  int checks    = 0;
  int passes    = 0;
  int send_to   = 0;
  int valid_cnt = 0;

  logic [DW-1:0]    ref_mem [DEPTH] = '{default: '0};
  logic [AW-1:0]    ref_wp = '0;
  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    obs_q[$];
  logic [AW+DW-1:0] wr_log[$];

  always @(negedge clk) begin
    if (bus.out_valid) begin
      obs_q.push_back(bus.out_data);
      valid_cnt++;
    end
    if (bus.mem_chipselect && bus.mem_write)
      wr_log.push_back({bus.mem_address, bus.mem_writedata});
  end

  task automatic reset_dut();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    ref_wp = '0;
`ifdef DELAY_CLEAR_EN
    begin
      int n = 0;
      while (!bus.in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    foreach (ref_mem[i]) ref_mem[i] = '0;
`else
    @(negedge clk);
`endif
    obs_q.delete();
    exp_q.delete();
    wr_log.delete();
  endtask

  // called on a negedge; returns on the negedge after the accept edge
  task automatic send(input logic [DW-1:0] s, input logic [AW-1:0] d);
    int n = 0;
    logic [AW-1:0] ra;
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    bus.delay    = d;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) begin
      ra = ref_wp - d;
      exp_q.push_back((d == '0) ? s : ref_mem[ra]);
      ref_mem[ref_wp] = s;
      ref_wp          = ref_wp + 1'b1;
    end else begin
      send_to++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (obs_q.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data: got %h want 0000", bus.out_data); else passes++;
    checks++; if (bus.mem_chipselect !== 1'b0) $display("FAIL reset_cs: got %b want 0", bus.mem_chipselect); else passes++;
    checks++; if (bus.mem_write !== 1'b0) $display("FAIL reset_write: got %b want 0", bus.mem_write); else passes++;
    checks++; if (bus.mem_address !== 11'h0) $display("FAIL reset_addr: got %h want 000", bus.mem_address); else passes++;
    checks++; if (bus.mem_writedata !== 16'h0) $display("FAIL reset_wdata: got %h want 0000", bus.mem_writedata); else passes++;
    checks++; if (bus.mem_byteenable !== 2'b11) $display("FAIL byteenable: got %b want 11", bus.mem_byteenable); else passes++;
    reset = 1'b0;
    @(negedge clk);
`ifdef DELAY_CLEAR_EN
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL post_reset_ready: got %b want 0", bus.in_ready); else passes++;
`else
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); else passes++;
`endif
  endtask

`ifdef DELAY_CLEAR_EN
  task automatic test_clear();
    int cnt = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wr_log.delete();
    reset = 1'b0;
    while (!bus.in_ready && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (cnt !== 2048) $display("FAIL clear_ready_low: got %0d cycles want 2048", cnt); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL clear_ready_after: got %b want 1", bus.in_ready); else passes++;
    checks++; if (wr_log.size() !== 2048) $display("FAIL clear_writes: got %0d want 2048", wr_log.size()); else passes++;
    for (int i = 0; i < DEPTH && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== {AW'(i), 16'h0}) $display("FAIL clear_entry[%0d]: got %h want %h", i, wr_log[i], {AW'(i), 16'h0});
      else passes++;
    end
    foreach (ref_mem[i]) ref_mem[i] = '0;
  endtask
`endif

  task automatic test_warmup();
    logic [DW-1:0] o, e;
    reset_dut();
    send_to = 0;
    for (int k = 1; k <= 10; k++) send(DW'(k), 11'd4);
    wait_out(10);
    exp_q.delete();
    checks++; if (send_to !== 0) $display("FAIL warmup_accept: got %0d timeouts want 0", send_to); else passes++;
    checks++; if (obs_q.size() !== 10) $display("FAIL warmup_count: got %0d want 10", obs_q.size()); else passes++;
    for (int k = 1; k <= 10; k++) begin
      e = (k <= 4) ? 16'h0 : DW'(k - 4);
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      checks++; if (o !== e) $display("FAIL warmup[%0d]: got %h want %h", k, o, e); else passes++;
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] o;
    reset_dut();
    send_to = 0;
    send(16'h7FFF, 11'd0);
    send(16'h8000, 11'd0);
    wait_out(2);
    exp_q.delete();
    checks++; if (send_to !== 0) $display("FAIL bypass_accept: got %0d timeouts want 0", send_to); else passes++;
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    checks++; if (o !== 16'h7FFF) $display("FAIL bypass_out0: got %h want 7fff", o); else passes++;
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    checks++; if (o !== 16'h8000) $display("FAIL bypass_out1: got %h want 8000", o); else passes++;
    checks++; if (wr_log.size() !== 2) $display("FAIL bypass_nwrites: got %0d want 2", wr_log.size()); else passes++;
    if (wr_log.size() >= 2) begin
      checks++; if (wr_log[0] !== {11'd0, 16'h7FFF}) $display("FAIL bypass_wr0: got %h want %h", wr_log[0], {11'd0, 16'h7FFF}); else passes++;
      checks++; if (wr_log[1] !== {11'd1, 16'h8000}) $display("FAIL bypass_wr1: got %h want %h", wr_log[1], {11'd1, 16'h8000}); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int ph;
    logic [AW-1:0] rd_exp, wr_exp;
    logic [DW-1:0] d_exp, o, e;
    rd_exp = '0;
    wr_exp = '0;
    d_exp  = '0;
    reset_dut();
    bus.in_valid = 1'b1;
    bus.delay    = 11'd3;
    for (int i = 0; i < 16; i++) begin
      ph = i % 4;
      checks++; if (bus.in_ready !== (ph == 0)) $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.in_ready, ph == 0); else passes++;
      checks++; if (bus.out_valid !== (ph == 3)) $display("FAIL b2b_valid[%0d]: got %b want %b", i, bus.out_valid, ph == 3); else passes++;
      checks++; if (bus.mem_chipselect !== (ph == 1 || ph == 2)) $display("FAIL b2b_cs[%0d]: got %b want %b", i, bus.mem_chipselect, ph == 1 || ph == 2); else passes++;
      checks++; if (bus.mem_write !== (ph == 2)) $display("FAIL b2b_write[%0d]: got %b want %b", i, bus.mem_write, ph == 2); else passes++;
      if (ph == 1) begin
        checks++; if (bus.mem_address !== rd_exp) $display("FAIL b2b_rd_addr[%0d]: got %h want %h", i, bus.mem_address, rd_exp); else passes++;
      end
      if (ph == 2) begin
        checks++; if (bus.mem_address !== wr_exp) $display("FAIL b2b_wr_addr[%0d]: got %h want %h", i, bus.mem_address, wr_exp); else passes++;
        checks++; if (bus.mem_writedata !== d_exp) $display("FAIL b2b_wdata[%0d]: got %h want %h", i, bus.mem_writedata, d_exp); else passes++;
      end
      if (ph == 0) begin
        d_exp       = 16'h0100 + DW'(i);
        bus.in_data = d_exp;
        rd_exp      = ref_wp - 11'd3;
        wr_exp      = ref_wp;
        exp_q.push_back(ref_mem[rd_exp]);
        ref_mem[ref_wp] = d_exp;
        ref_wp          = ref_wp + 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_out(4);
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      checks++; if (o !== e) $display("FAIL b2b_data: got %h want %h", o, e); else passes++;
    end
  endtask

  task automatic test_reset_in_rd();
    int v0;
    logic [DW-1:0] o, e;
    reset_dut();
    send_to      = 0;
    bus.delay    = 11'd5;
    bus.in_data  = 16'hAAAA;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b0) $display("FAIL rd_phase: got cs=%b we=%b want cs=1 we=0", bus.mem_chipselect, bus.mem_write); else passes++;
    checks++; if (bus.mem_address !== 11'd2043) $display("FAIL rd_addr_wrap: got %h want 7fb", bus.mem_address); else passes++;
    v0 = valid_cnt;
    reset_dut();
    repeat (6) @(negedge clk);
    checks++; if (valid_cnt !== v0) $display("FAIL rd_reset_no_valid: got %0d strobes want 0", valid_cnt - v0); else passes++;
    send(16'h1234, 11'd5);
    wait_out(1);
    checks++; if (send_to !== 0) $display("FAIL rd_reset_accept: got %0d timeouts want 0", send_to); else passes++;
    checks++; if (wr_log.size() < 1 || wr_log[0] !== {11'd0, 16'h1234}) $display("FAIL rd_reset_wr0: got %h want %h", (wr_log.size() > 0) ? wr_log[0] : 27'h0, {11'd0, 16'h1234}); else passes++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
    checks++; if (o !== e) $display("FAIL rd_reset_out: got %h want %h", o, e); else passes++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] o, e;
    reset_dut();
    send_to = 0;
    for (int k = 1; k <= 2050; k++) send(DW'(k), 11'd2047);
    wait_out(2050);
    checks++; if (send_to !== 0) $display("FAIL wrap_accept: got %0d timeouts want 0", send_to); else passes++;
    checks++; if (obs_q.size() !== 2050) $display("FAIL wrap_count: got %0d want 2050", obs_q.size()); else passes++;
    checks++; if (wr_log.size() !== 2050) $display("FAIL wrap_nwrites: got %0d want 2050", wr_log.size()); else passes++;
    if (wr_log.size() >= 2050) begin
      checks++; if (wr_log[2047] !== {11'd2047, 16'd2048}) $display("FAIL wrap_wr_last: got %h want %h", wr_log[2047], {11'd2047, 16'd2048}); else passes++;
      checks++; if (wr_log[2048] !== {11'd0, 16'd2049}) $display("FAIL wrap_wr_first: got %h want %h", wr_log[2048], {11'd0, 16'd2049}); else passes++;
    end
    if (obs_q.size() >= 2050) begin
      for (int n = 2048; n <= 2050; n++) begin
        checks++; if (obs_q[n-1] !== DW'(n - 2047)) $display("FAIL wrap_out[%0d]: got %h want %h", n, obs_q[n-1], DW'(n - 2047)); else passes++;
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
      checks++; if (o !== e) $display("FAIL wrap_data: got %h want %h", o, e); else passes++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.delay    = '0;
    test_reset();
`ifdef DELAY_CLEAR_EN
    test_clear();
`endif
    test_warmup();
    test_bypass();
    test_back_to_back();
    test_reset_in_rd();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
